key_debounce_intr: RTL and testbench
====================================

Name: key_debounce_intr

Overview:
- Sits directly downstream of the keypad row-scan FSM.
- Consumes its raw 4-bit key code (4'hF = no key) and its load strobe.
- Produces one debounced, de-duplicated key event per physical press: a held key code, a valid/ack handshake, and a one-cycle interrupt pulse for the RAT CPU.
- Runs on the same 500 kHz scan clock.

Parameters:
- DB_CYCLES, 5000, consecutive qualified samples of an identical non-F code required to accept a press (10 ms at 500 kHz); legal range 2..65535.
- REL_CYCLES, 5000, consecutive qualified samples of 4'hF required to accept a release; legal range 2..65535.
- CNT_W, $clog2(max(DB_CYCLES,REL_CYCLES)+1), derived width of the shared sample counter; not overridden.

Ports:
- CLK_500KHz  in  1  scan clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- BUTTON_PRESS  in  4  raw key code from the scanner; 4'hF means no key.
- REG_LD  in  1  sample qualifier; BUTTON_PRESS is only examined when REG_LD = 1.
- KEY_ACK  in  1  CPU acknowledge; one-cycle pulse clears KEY_VALID and OVERRUN.
- KEY_CODE  out  4  last accepted key code; registered.
- KEY_VALID  out  1  high from acceptance until KEY_ACK.
- KEY_INTR  out  1  one-cycle pulse on each accepted press.
- OVERRUN  out  1  sticky; set when a new press is accepted while KEY_VALID = 1 and not being acked.

Behaviour:
- Reset (RST_N = 0, asynchronous):
  - state = IDLE, counter = 0, candidate = 4'hF.
  - KEY_CODE = 4'hF; KEY_VALID, KEY_INTR and OVERRUN = 0.
  - Deassertion takes effect on the next clock edge.
  - Reset mid-debounce discards the candidate with no event.
- Cycles with REG_LD = 0: FSM, counter and candidate hold. KEY_ACK is still honoured and KEY_INTR still self-clears.
- States: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. All transitions below apply only on qualified samples.
- IDLE:
  - Code ≠ F: candidate <= code, counter <= 1, go to PRESS_WAIT.
  - Code = F: stay.
- PRESS_WAIT:
  - Code = candidate and counter = DB_CYCLES−1: accept the press, go to HELD, counter <= 0.
  - Code = candidate otherwise: counter++.
  - Code ≠ candidate and ≠ F: candidate <= code, counter <= 1 (restart on the new key).
  - Code = F: go to IDLE, counter <= 0.
- HELD:
  - Code ≠ F: stay. No auto-repeat, even if the code changes.
  - Code = F: go to RELEASE_WAIT, counter <= 1.
- RELEASE_WAIT:
  - Code = F and counter = REL_CYCLES−1: go to IDLE.
  - Code = F otherwise: counter++.
  - Code ≠ F: return to HELD, counter <= 0. A bounce during release never produces a second event.
- Latency: the accept decision is made on the DB_CYCLES-th matching qualified sample. On the next clock edge, KEY_CODE <= candidate, KEY_VALID <= 1 and KEY_INTR <= 1, all together. KEY_INTR drops on the following edge.
- Handshake:
  - KEY_ACK with no accept that cycle: KEY_VALID <= 0, OVERRUN <= 0.
  - Accept while KEY_VALID = 1 and no KEY_ACK: KEY_CODE is overwritten, OVERRUN <= 1, KEY_VALID stays 1.
  - Accept and KEY_ACK in the same cycle: the ack consumes the old event; new code loaded, KEY_VALID stays 1, OVERRUN <= 0.
  - KEY_ACK while KEY_VALID = 0: no effect.
- Counter never wraps: it saturates by construction, since every path resets it before reaching its limit. Width is CNT_W.

Decomposition:
- Shared package kbd_pkg holds:
  - enum key_db_state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - localparam KEY_NONE = 4'hF;
  - default debounce constants.
- One natural sub-module: key_evt_reg. It owns KEY_CODE, KEY_VALID, KEY_INTR and OVERRUN, driven by an accept strobe, the candidate code and KEY_ACK.
- The FSM and counter stay in the top module.

Test Plan:
- Bench uses DB_CYCLES=4, REL_CYCLES=3.
- Reset: RST_N low mid-PRESS_WAIT with code 4'h5 -> all outputs 0 and KEY_CODE=4'hF immediately (asynchronous); no KEY_INTR after release.
- Clean press: REG_LD=1, code 4'h7 for 4 cycles then F for 3 -> single KEY_INTR pulse one cycle after the 4th sample; KEY_CODE=4'h7, KEY_VALID=1; KEY_ACK clears KEY_VALID.
- Bounce: code sequence 7,7,F,7,7,7,7 -> exactly one accept, on the last sample. Sequence 7,3,3,3,3 -> KEY_CODE=4'h3.
- Release bounce: hold 4'hA accepted, then F,F,A,F,F,F,2,2,2,2 -> two KEY_INTR pulses total (A, then 2). The A during release produces no event.
- REG_LD gating: code 4'h1 with REG_LD toggling 1,0,1,0,1,0,1 -> accept only after the 4th qualified sample; counter holds on REG_LD=0 cycles.
- Overrun: accept 4'h4, no ack, full release, accept 4'h9 -> KEY_CODE=4'h9, OVERRUN=1. Repeat with KEY_ACK coincident with the second accept -> OVERRUN=0, KEY_VALID=1.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the keypad debounce / interrupt path.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_db_state_t;

  localparam logic [3:0] KEY_NONE = 4'hF;

  // 10 ms at the 500 kHz scan clock
  localparam int DB_CYCLES_DFLT  = 5000;
  localparam int REL_CYCLES_DFLT = 5000;

endpackage

// File: rtl/key_evt_reg.sv
// Holds the last accepted key event and the valid/ack/overrun handshake
// towards the CPU; emits a one-cycle interrupt per accepted press.
module key_evt_reg
  import kbd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       accept_i,
  input  logic [3:0] cand_i,
  input  logic       ack_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_intr_o,
  output logic       overrun_o
);

  logic [3:0] code_q,  code_d;
  logic       valid_q, valid_d;
  logic       intr_q,  intr_d;
  logic       ovr_q,   ovr_d;

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    intr_d  = 1'b0;
    ovr_d   = ovr_q;
    if (accept_i) begin
      code_d  = cand_i;
      valid_d = 1'b1;
      intr_d  = 1'b1;
      // A coincident ack consumes the old event, so nothing was lost.
      if (ack_i)        ovr_d = 1'b0;
      else if (valid_q) ovr_d = 1'b1;
    end else if (ack_i && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_q  <= KEY_NONE;
      valid_q <= 1'b0;
      intr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      intr_q  <= intr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign key_code_o  = code_q;
  assign key_valid_o = valid_q;
  assign key_intr_o  = intr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: rtl/key_debounce_intr.sv
// Debounces the keypad scanner's raw code into one event per physical press,
// with release debouncing so bounce on key-up never re-triggers.
module key_debounce_intr
  import kbd_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DFLT,
  parameter int REL_CYCLES = REL_CYCLES_DFLT
) (
  input  logic       CLK_500KHz,
  input  logic       RST_N,
  input  logic [3:0] BUTTON_PRESS,
  input  logic       REG_LD,
  input  logic       KEY_ACK,
  output logic [3:0] KEY_CODE,
  output logic       KEY_VALID,
  output logic       KEY_INTR,
  output logic       OVERRUN
);

  localparam int CNT_MAX = (DB_CYCLES > REL_CYCLES) ? DB_CYCLES : REL_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  key_db_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       cand_q,  cand_d;
  logic             accept;
  logic             is_none;

  assign is_none = (BUTTON_PRESS == KEY_NONE);

  // Every path clears or restarts the counter before it reaches its limit,
  // so it never needs explicit saturation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (REG_LD) begin
      unique case (state_q)
        IDLE: begin
          if (!is_none) begin
            cand_d  = BUTTON_PRESS;
            cnt_d   = CNT_ONE;
            state_d = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (is_none) begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end else if (BUTTON_PRESS == cand_q) begin
            if (cnt_q == DB_LAST) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cand_d = BUTTON_PRESS;
            cnt_d  = CNT_ONE;
          end
        end
        HELD: begin
          // No auto-repeat: a code change while held is ignored.
          if (is_none) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (is_none) begin
            if (cnt_q == REL_LAST) begin
              state_d = IDLE;
              cnt_d   = CNT_ZERO;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = HELD;
            cnt_d   = CNT_ZERO;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_500KHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      cand_q  <= KEY_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

  key_evt_reg u_evt (
    .clk_i       (CLK_500KHz),
    .rst_ni      (RST_N),
    .accept_i    (accept),
    .cand_i      (cand_q),
    .ack_i       (KEY_ACK),
    .key_code_o  (KEY_CODE),
    .key_valid_o (KEY_VALID),
    .key_intr_o  (KEY_INTR),
    .overrun_o   (OVERRUN)
  );

endmodule

// File: tb/tb_key_debounce_intr.sv
// Directed bench for key_debounce_intr with short debounce windows.
module tb_key_debounce_intr;

  logic       clk;
  logic       rst_n;
  logic [3:0] bp;
  logic       ld;
  logic       ack;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_intr;
  logic       overrun;

  int n_chk  = 0;
  int n_pass = 0;
  int intr_cnt = 0;

  key_debounce_intr #(.DB_CYCLES(4), .REL_CYCLES(3)) dut (
    .CLK_500KHz   (clk),
    .RST_N        (rst_n),
    .BUTTON_PRESS (bp),
    .REG_LD       (ld),
    .KEY_ACK      (ack),
    .KEY_CODE     (key_code),
    .KEY_VALID    (key_valid),
    .KEY_INTR     (key_intr),
    .OVERRUN      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Present one sample for one cycle; outputs are observed 1 time unit after the edge.
  task automatic step(input logic [3:0] c, input logic l, input logic a);
    @(negedge clk);
    bp  = c;
    ld  = l;
    ack = a;
    @(posedge clk);
    #1;
    if (key_intr) intr_cnt++;
  endtask

  task automatic hold(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) step(c, 1'b1, 1'b0);
  endtask

  task automatic do_ack();
    step(4'hF, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    bp    = 4'hF;
    ld    = 1'b0;
    ack   = 1'b0;
    #12;
    chk("rst_code",  {28'd0, key_code}, 32'hF);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_intr",  {31'd0, key_intr}, 32'd0);
    chk("rst_ovr",   {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-debounce discards the candidate
    hold(4'h5, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_code",  {28'd0, key_code}, 32'hF);
    chk("arst_valid", {31'd0, key_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(4'h5, 2);
    hold(4'hF, 3);
    chk("arst_no_intr", intr_cnt, 0);
    chk("arst_valid2", {31'd0, key_valid}, 32'd0);

    // Clean press
    hold(4'h7, 3);
    chk("clean_pre_intr", {31'd0, key_intr}, 32'd0);
    hold(4'h7, 1);
    chk("clean_intr",  {31'd0, key_intr}, 32'd1);
    chk("clean_code",  {28'd0, key_code}, 32'h7);
    chk("clean_valid", {31'd0, key_valid}, 32'd1);
    hold(4'hF, 1);
    chk("clean_intr_drop", {31'd0, key_intr}, 32'd0);
    hold(4'hF, 2);
    chk("clean_count", intr_cnt, 1);
    do_ack();
    chk("clean_ack_valid", {31'd0, key_valid}, 32'd0);
    chk("clean_ack_code",  {28'd0, key_code}, 32'h7);

    // Bounce on press: 7,7,F,7,7,7,7
    intr_cnt = 0;
    hold(4'h7, 2);
    hold(4'hF, 1);
    hold(4'h7, 3);
    chk("bounce_none_yet", intr_cnt, 0);
    hold(4'h7, 1);
    chk("bounce_one", intr_cnt, 1);
    hold(4'hF, 3);
    do_ack();

    // Key change restarts: 7,3,3,3,3
    hold(4'h7, 1);
    hold(4'h3, 3);
    chk("switch_none_yet", intr_cnt, 1);
    hold(4'h3, 1);
    chk("switch_code", {28'd0, key_code}, 32'h3);
    chk("switch_count", intr_cnt, 2);
    hold(4'hF, 3);
    do_ack();

    // Release bounce: A accepted, then F,F,A,F,F,F,2,2,2,2
    intr_cnt = 0;
    hold(4'hA, 4);
    chk("rel_code_a", {28'd0, key_code}, 32'hA);
    hold(4'hF, 2);
    hold(4'hA, 1);
    hold(4'hF, 3);
    chk("rel_bounce_quiet", intr_cnt, 1);
    hold(4'h2, 4);
    chk("rel_two_events", intr_cnt, 2);
    chk("rel_code_2", {28'd0, key_code}, 32'h2);
    hold(4'hF, 3);
    do_ack();
    chk("rel_ack_ovr", {31'd0, overrun}, 32'd0);

    // REG_LD gating: 1 with ld 1,0,1,0,1,0,1
    intr_cnt = 0;
    step(4'h1, 1'b1, 1'b0);
    step(4'h1, 1'b0, 1'b0);
    step(4'h1, 1'b1, 1'b0);
    step(4'h1, 1'b0, 1'b0);
    step(4'h1, 1'b1, 1'b0);
    step(4'h1, 1'b0, 1'b0);
    chk("ld_none_yet", intr_cnt, 0);
    step(4'h1, 1'b1, 1'b0);
    chk("ld_intr", {31'd0, key_intr}, 32'd1);
    chk("ld_code", {28'd0, key_code}, 32'h1);
    hold(4'hF, 3);
    do_ack();

    // Overrun: second accept with no ack
    hold(4'h4, 4);
    hold(4'hF, 3);
    hold(4'h9, 4);
    chk("ovr_code",  {28'd0, key_code}, 32'h9);
    chk("ovr_set",   {31'd0, overrun}, 32'd1);
    chk("ovr_valid", {31'd0, key_valid}, 32'd1);
    do_ack();
    chk("ovr_ack_clr",   {31'd0, overrun}, 32'd0);
    chk("ovr_ack_valid", {31'd0, key_valid}, 32'd0);
    do_ack();
    chk("ack_idle_valid", {31'd0, key_valid}, 32'd0);
    hold(4'hF, 3);

    // Ack coincident with the second accept
    hold(4'h4, 4);
    hold(4'hF, 3);
    hold(4'h9, 3);
    step(4'h9, 1'b1, 1'b1);
    chk("coack_code",  {28'd0, key_code}, 32'h9);
    chk("coack_ovr",   {31'd0, overrun}, 32'd0);
    chk("coack_valid", {31'd0, key_valid}, 32'd1);
    chk("coack_intr",  {31'd0, key_intr}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
